// File: rtl/burst_addr_gen_if.sv
// burst_addr_gen_if
// Bundles the request, serial load, beat handshake and serial address
// signals of the burst address generator so they travel as one port.
//   start, mode        burst request and its mode (00 SINGLE, 01 INCR, 10 WRAP)
//   len_ser_in         serial burst length, MSB first
//   addr_ser_in        serial start address, MSB first
//   beat_ack, abort    per-beat acknowledge and synchronous burst cancel
//   addr_sel           generator owns the serial address line
//   addr_ser_out       serial beat address, MSB first
//   addr_frame         qualifies the bits on addr_ser_out
//   busy, done, err    status; done and err are one-cycle pulses
//   beat_cnt           index of the beat currently presented
// The slave modport is the generator, the master modport is its driver.
interface burst_addr_gen_if #(
  parameter int LEN_WIDTH = 5
);
  logic                 start;
  logic [1:0]           mode;
  logic                 len_ser_in;
  logic                 addr_ser_in;
  logic                 beat_ack;
  logic                 abort;
  logic                 addr_sel;
  logic                 addr_ser_out;
  logic                 addr_frame;
  logic                 busy;
  logic                 done;
  logic                 err;
  logic [LEN_WIDTH-1:0] beat_cnt;

  modport master (
    output start, mode, len_ser_in, addr_ser_in, beat_ack, abort,
    input  addr_sel, addr_ser_out, addr_frame, busy, done, err, beat_cnt
  );

  modport slave (
    input  start, mode, len_ser_in, addr_ser_in, beat_ack, abort,
    output addr_sel, addr_ser_out, addr_frame, busy, done, err, beat_cnt
  );
endinterface

// File: rtl/burst_addr_gen.sv
// burst_addr_gen
// Deserialises a burst length and a start address, then produces one beat
// address per beat in SINGLE, INCR or WRAP mode and shifts each one out
// MSB first. Every beat waits for beat_ack before the next one is computed.
//   clk   system clock, rising edge
//   rst   asynchronous, active-low reset
//   bus   burst_addr_gen_if.slave carrying all request/serial/status signals
module burst_addr_gen #(
  parameter int ADDR_WIDTH = 20,
  parameter int LEN_WIDTH  = 5,
  parameter int ADDR_STEP  = 1
) (
  input logic             clk,
  input logic             rst,
  burst_addr_gen_if.slave bus
);

  localparam int CNT_MAX = (ADDR_WIDTH > LEN_WIDTH) ? ADDR_WIDTH : LEN_WIDTH;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [1:0] MODE_SINGLE = 2'b00;
  localparam logic [1:0] MODE_WRAP   = 2'b10;

  typedef enum logic [2:0] {
    IDLE,
    LOAD_LEN,
    LOAD_ADDR,
    CALC,
    SHIFT,
    WAIT_ACK
  } state_t;

  state_t                state_q;
  state_t                state_d;
  logic [1:0]            mode_q;
  logic [LEN_WIDTH-1:0]  len_q;
  logic [LEN_WIDTH-1:0]  beat_cnt_q;
  logic [ADDR_WIDTH-1:0] start_addr_q;
  logic [ADDR_WIDTH-1:0] shift_q;
  logic [CNT_W-1:0]      cnt_q;
  logic                  done_q;

  logic [LEN_WIDTH:0]    beats;
  logic                  beats_pow2;
  logic                  use_wrap;
  logic                  last_beat;
  logic [ADDR_WIDTH-1:0] offset;
  logic [ADDR_WIDTH-1:0] linear_addr;
  logic [ADDR_WIDTH-1:0] wrap_mask;
  logic [ADDR_WIDTH-1:0] beat_addr;

  // Beat address arithmetic. A WRAP burst whose beat count is not a power of
  // two falls back to linear addressing. When beats*ADDR_STEP reaches or
  // exceeds the address space the truncated product is zero, so the mask
  // becomes all ones and the burst wraps over the whole space.
  always_comb begin
    beats       = {1'b0, len_q} + (LEN_WIDTH + 1)'(1);
    beats_pow2  = (beats & (beats - (LEN_WIDTH + 1)'(1))) == '0;
    use_wrap    = (mode_q == MODE_WRAP) && beats_pow2;
    last_beat   = beat_cnt_q == len_q;
    offset      = ADDR_WIDTH'(beat_cnt_q) * ADDR_WIDTH'(ADDR_STEP);
    linear_addr = start_addr_q + offset;
    wrap_mask   = (ADDR_WIDTH'(beats) * ADDR_WIDTH'(ADDR_STEP)) - ADDR_WIDTH'(1);
    beat_addr   = use_wrap ? ((start_addr_q & ~wrap_mask) | (linear_addr & wrap_mask))
                           : linear_addr;
  end

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state and outputs. Abort overrides every transition, including a
  // beat_ack arriving in the same cycle.
  always_comb begin
    state_d          = state_q;
    bus.addr_sel     = 1'b0;
    bus.busy         = 1'b0;
    bus.addr_frame   = 1'b0;
    bus.addr_ser_out = 1'b0;
    bus.err          = 1'b0;
    bus.done         = done_q;
    bus.beat_cnt     = beat_cnt_q;

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d = (bus.mode == MODE_SINGLE) ? LOAD_ADDR : LOAD_LEN;
        end
      end
      LOAD_LEN: begin
        if (cnt_q == CNT_W'(LEN_WIDTH - 1)) state_d = LOAD_ADDR;
      end
      LOAD_ADDR: begin
        if (cnt_q == CNT_W'(ADDR_WIDTH - 1)) state_d = CALC;
      end
      CALC: begin
        state_d = SHIFT;
        bus.err = (beat_cnt_q == '0) && (mode_q == MODE_WRAP) && !beats_pow2;
      end
      SHIFT: begin
        bus.addr_frame   = 1'b1;
        bus.addr_ser_out = shift_q[ADDR_WIDTH-1];
        if (cnt_q == CNT_W'(ADDR_WIDTH - 1)) state_d = WAIT_ACK;
      end
      WAIT_ACK: begin
        if (bus.beat_ack) state_d = last_beat ? IDLE : CALC;
      end
      default: state_d = IDLE;
    endcase

    if (state_q != IDLE) begin
      bus.addr_sel = 1'b1;
      bus.busy     = 1'b1;
      if (bus.abort) state_d = IDLE;
    end
  end

  // Datapath: serial capture, shift register, bit counter, beat counter and
  // the done pulse. The bit counter restarts on every state change so each
  // counted state sees 0..N-1. beat_cnt returns to 0 whenever the burst ends.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mode_q       <= '0;
      len_q        <= '0;
      beat_cnt_q   <= '0;
      start_addr_q <= '0;
      shift_q      <= '0;
      cnt_q        <= '0;
      done_q       <= 1'b0;
    end else begin
      done_q <= (state_q == WAIT_ACK) && bus.beat_ack && last_beat && !bus.abort;

      if (state_d != state_q) begin
        cnt_q <= '0;
      end else if (state_q == LOAD_LEN || state_q == LOAD_ADDR || state_q == SHIFT) begin
        cnt_q <= cnt_q + CNT_W'(1);
      end

      case (state_q)
        IDLE: begin
          if (bus.start) begin
            mode_q <= bus.mode;
            len_q  <= '0;
          end
        end
        LOAD_LEN:  len_q        <= (len_q << 1) | LEN_WIDTH'(bus.len_ser_in);
        LOAD_ADDR: start_addr_q <= (start_addr_q << 1) | ADDR_WIDTH'(bus.addr_ser_in);
        CALC:      shift_q      <= beat_addr;
        SHIFT:     shift_q      <= shift_q << 1;
        WAIT_ACK: begin
          if (bus.beat_ack && !last_beat) beat_cnt_q <= beat_cnt_q + LEN_WIDTH'(1);
        end
        default: ;
      endcase

      if (state_d == IDLE) beat_cnt_q <= '0;
    end
  end

endmodule

// File: tb/tb_burst_addr_gen.sv
// tb_burst_addr_gen
// Drives two burst_addr_gen instances (ADDR_STEP 1 and 4) with identical
// stimulus, reassembles their serial frames and compares them with a
// reference model built from block-aligned modular arithmetic.
module tb_burst_addr_gen;
  localparam int AW   = 20;
  localparam int LW   = 5;
  localparam int MAXF = 2048;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic          start       = 1'b0;
  logic [1:0]    mode        = 2'b00;
  logic          len_ser_in  = 1'b0;
  logic          addr_ser_in = 1'b0;
  logic          beat_ack    = 1'b0;
  logic          abort       = 1'b0;

  int checks = 0;
  int errors = 0;

  burst_addr_gen_if #(.LEN_WIDTH(LW)) bus0 ();
  burst_addr_gen_if #(.LEN_WIDTH(LW)) bus1 ();

  assign bus0.start       = start;
  assign bus0.mode        = mode;
  assign bus0.len_ser_in  = len_ser_in;
  assign bus0.addr_ser_in = addr_ser_in;
  assign bus0.beat_ack    = beat_ack;
  assign bus0.abort       = abort;
  assign bus1.start       = start;
  assign bus1.mode        = mode;
  assign bus1.len_ser_in  = len_ser_in;
  assign bus1.addr_ser_in = addr_ser_in;
  assign bus1.beat_ack    = beat_ack;
  assign bus1.abort       = abort;

  burst_addr_gen #(.ADDR_WIDTH(AW), .LEN_WIDTH(LW), .ADDR_STEP(1)) dut0 (
    .clk(clk), .rst(rst), .bus(bus0.slave)
  );
  burst_addr_gen #(.ADDR_WIDTH(AW), .LEN_WIDTH(LW), .ADDR_STEP(4)) dut1 (
    .clk(clk), .rst(rst), .bus(bus1.slave)
  );

  // Frame collector, one lane per instance.
  logic [1:0]    m_frame, m_bit, m_err, m_done;
  logic [LW-1:0] m_bc [2];
  assign m_frame = {bus1.addr_frame, bus0.addr_frame};
  assign m_bit   = {bus1.addr_ser_out, bus0.addr_ser_out};
  assign m_err   = {bus1.err, bus0.err};
  assign m_done  = {bus1.done, bus0.done};
  assign m_bc[0] = bus0.beat_cnt;
  assign m_bc[1] = bus1.beat_cnt;

  logic [AW-1:0] frames     [2][MAXF];
  logic [LW-1:0] frame_beat [2][MAXF];
  int            frame_cyc  [2][MAXF];
  int            n_frames   [2] = '{0, 0};
  int            err_cnt    [2] = '{0, 0};
  int            done_cnt   [2] = '{0, 0};
  int            nbits      [2] = '{0, 0};
  logic [AW-1:0] acc        [2];
  int            cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (m_err[k]) err_cnt[k] <= err_cnt[k] + 1;
      if (m_done[k]) done_cnt[k] <= done_cnt[k] + 1;
      if (m_frame[k]) begin
        if (nbits[k] == 0 && n_frames[k] < MAXF) begin
          frame_cyc[k][n_frames[k]]  <= cyc;
          frame_beat[k][n_frames[k]] <= m_bc[k];
        end
        if (nbits[k] == AW - 1) begin
          if (n_frames[k] < MAXF) frames[k][n_frames[k]] <= {acc[k][AW-2:0], m_bit[k]};
          n_frames[k] <= n_frames[k] + 1;
          nbits[k]    <= 0;
        end else begin
          acc[k]   <= {acc[k][AW-2:0], m_bit[k]};
          nbits[k] <= nbits[k] + 1;
        end
      end else begin
        nbits[k] <= 0;
      end
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic bit is_pow2(input int v);
    return (v & (v - 1)) == 0;
  endfunction

  // Reference: linear beats advance by step modulo the address space; a
  // power-of-two WRAP burst stays inside the block of size beats*step that
  // contains the start address.
  function automatic logic [AW-1:0] ref_addr(input logic [AW-1:0] base_addr, input int idx,
                                             input int beats, input logic [1:0] m, input int step);
    longint space, block, s, lo;
    space = longint'(1) << AW;
    s     = longint'(base_addr);
    if (m == 2'b10 && is_pow2(beats)) begin
      block = longint'(beats) * step;
      if (block > space) block = space;
      lo = s - (s % block);
      return AW'(lo + ((s % block) + longint'(idx) * step) % block);
    end
    return AW'((s + longint'(idx) * step) % space);
  endfunction

  task automatic check_outputs_zero(input string tag);
    checkOutput({tag, "_sel0"},   32'(bus0.addr_sel),     0);
    checkOutput({tag, "_frame0"}, 32'(bus0.addr_frame),   0);
    checkOutput({tag, "_busy0"},  32'(bus0.busy),         0);
    checkOutput({tag, "_bc0"},    32'(bus0.beat_cnt),     0);
    checkOutput({tag, "_done0"},  32'(bus0.done),         0);
    checkOutput({tag, "_ser0"},   32'(bus0.addr_ser_out), 0);
    checkOutput({tag, "_busy1"},  32'(bus1.busy),         0);
    checkOutput({tag, "_bc1"},    32'(bus1.beat_cnt),     0);
  endtask

  task automatic wait_frame(input logic level, output bit ok);
    ok = 1'b0;
    for (int c = 0; c < 200; c++) begin
      if (bus0.addr_frame === level) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    checkOutput("frame_wait", 32'(ok), 1);
  endtask

  task automatic load_burst(input logic [1:0] m, input int len, input logic [AW-1:0] addr);
    logic [LW-1:0] lv;
    lv    = LW'(len);
    start = 1'b1;
    mode  = m;
    tick();
    start = 1'b0;
    if (m != 2'b00) begin
      for (int b = LW - 1; b >= 0; b--) begin
        len_ser_in = lv[b];
        tick();
      end
    end
    for (int b = AW - 1; b >= 0; b--) begin
      addr_ser_in = addr[b];
      tick();
    end
    len_ser_in  = 1'b0;
    addr_ser_in = 1'b0;
  endtask

  task automatic applyStimulus(input logic [1:0] m, input int len, input logic [AW-1:0] addr,
                               input bit held, input int abort_beat, input bit poke);
    int  base_f [2];
    int  base_e [2];
    int  base_d [2];
    int  beats, exp_frames, got_frames, step;
    bit  ok, aborted;
    aborted = 1'b0;
    beats   = (m == 2'b00) ? 1 : len + 1;
    for (int k = 0; k < 2; k++) begin
      base_f[k] = n_frames[k];
      base_e[k] = err_cnt[k];
      base_d[k] = done_cnt[k];
    end
    checkOutput("idle_sel", 32'(bus0.addr_sel), 0);
    load_burst(m, len, addr);

    if (held) begin
      beat_ack = 1'b1;
      for (int c = 0; c < beats * (AW + 2) + 20; c++) begin
        if (!bus0.busy) break;
        start = poke && (c == 5);
        tick();
      end
      start = 1'b0;
      checkOutput("held_end_busy", 32'(bus0.busy), 0);
      beat_ack = 1'b0;
    end else begin
      for (int i = 0; i < beats; i++) begin
        wait_frame(1'b1, ok);
        if (!ok) break;
        if (poke && i == 0) begin
          start = 1'b1;
          mode  = ~m;
          tick();
          start = 1'b0;
          mode  = m;
        end
        if (i == abort_beat) begin
          repeat ($urandom_range(1, 10)) tick();
          abort    = 1'b1;
          beat_ack = 1'b1;
          tick();
          abort    = 1'b0;
          beat_ack = 1'b0;
          check_outputs_zero("abort");
          tick();
          checkOutput("abort_done_after", 32'(bus0.done), 0);
          aborted = 1'b1;
          break;
        end
        wait_frame(1'b0, ok);
        if (!ok) break;
        repeat ($urandom_range(0, 2)) tick();
        beat_ack = 1'b1;
        tick();
        beat_ack = 1'b0;
        if (i == beats - 1) begin
          checkOutput("done_latency", 32'(bus0.done), 1);
          checkOutput("done_sel", 32'(bus0.addr_sel), 0);
          tick();
          checkOutput("done_width", 32'(bus0.done), 0);
        end
      end
    end
    repeat (2) tick();

    exp_frames = aborted ? abort_beat : beats;
    for (int k = 0; k < 2; k++) begin
      step       = (k == 0) ? 1 : 4;
      got_frames = n_frames[k] - base_f[k];
      checkOutput($sformatf("n_frames[%0d]", k), 32'(got_frames), 32'(exp_frames));
      for (int j = 0; j < exp_frames && j < got_frames && base_f[k] + j < MAXF; j++) begin
        checkOutput($sformatf("addr[%0d] beat %0d", k, j), 32'(frames[k][base_f[k] + j]),
                    32'(ref_addr(addr, j, beats, m, step)));
        checkOutput($sformatf("beat_cnt[%0d] beat %0d", k, j),
                    32'(frame_beat[k][base_f[k] + j]), 32'(j));
        if (held && k == 0 && j > 0) begin
          checkOutput($sformatf("spacing beat %0d", j),
                      32'(frame_cyc[k][base_f[k] + j] - frame_cyc[k][base_f[k] + j - 1]), AW + 2);
        end
      end
      checkOutput($sformatf("err[%0d]", k), 32'(err_cnt[k] - base_e[k]),
                  (m == 2'b10 && !is_pow2(beats)) ? 1 : 0);
      checkOutput($sformatf("done[%0d]", k), 32'(done_cnt[k] - base_d[k]), aborted ? 0 : 1);
    end
  endtask

  initial begin
    #900000;
    $display("[TB] FAIL watchdog: simulation did not end, checks %0d", checks);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    bit ok;
    int len, abort_beat, beats;
    logic [1:0] m;
    logic [AW-1:0] addr;
    bit held, poke;

    repeat (3) tick();
    check_outputs_zero("reset");
    #2 rst = 1'b1;
    repeat (2) tick();

    applyStimulus(2'b00, 0, 20'h12345, 1'b0, -1, 1'b0);
    applyStimulus(2'b01, 3, 20'h00010, 1'b0, -1, 1'b0);
    applyStimulus(2'b01, 3, 20'h00010, 1'b1, -1, 1'b0);
    applyStimulus(2'b01, 3, 20'hFFFFE, 1'b0, -1, 1'b0);
    applyStimulus(2'b10, 3, 20'h00006, 1'b0, -1, 1'b0);
    applyStimulus(2'b10, 3, 20'h00018, 1'b1, -1, 1'b0);
    applyStimulus(2'b10, 2, 20'h00006, 1'b0, -1, 1'b0);
    applyStimulus(2'b11, 1, 20'hABCDE, 1'b0, -1, 1'b0);
    applyStimulus(2'b01, 3, 20'h00040, 1'b0, 1, 1'b1);

    // Asynchronous reset during the second beat's frame.
    load_burst(2'b01, 3, 20'h00100);
    wait_frame(1'b1, ok);
    wait_frame(1'b0, ok);
    beat_ack = 1'b1;
    tick();
    beat_ack = 1'b0;
    wait_frame(1'b1, ok);
    repeat (5) tick();
    checkOutput("pre_reset_bc", 32'(bus0.beat_cnt), 1);
    #2 rst = 1'b0;
    #1;
    check_outputs_zero("async_rst");
    tick();
    #2 rst = 1'b1;
    tick();
    applyStimulus(2'b01, 3, 20'h00200, 1'b0, -1, 1'b0);

    for (int n = 0; n < 24; n++) begin
      m    = 2'($urandom_range(0, 3));
      len  = ($urandom_range(0, 4) == 0) ? $urandom_range(0, 15) : $urandom_range(0, 7);
      addr = AW'($urandom);
      if ($urandom_range(0, 3) == 0) addr = 20'hFFFF0 | AW'($urandom_range(0, 15));
      beats      = (m == 2'b00) ? 1 : len + 1;
      held       = 1'($urandom_range(0, 1));
      poke       = $urandom_range(0, 3) == 0;
      abort_beat = (!held && $urandom_range(0, 4) == 0) ? $urandom_range(0, beats - 1) : -1;
      applyStimulus(m, len, addr, held, abort_beat, poke);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
